// File: rtl/fpmul_mmio.sv
// Memory-mapped front end for the floating-point multiplier core: operand, control,
// status and result registers plus a launch/wait FSM with a sticky done flag and an interrupt.
module fpmul_mmio #(
  parameter int DATA_W = 32,
  parameter int N_OPS  = 2,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wd,
  output logic [DATA_W-1:0]       rd,
  output logic                    irq,
  output logic                    core_start,
  output logic [N_OPS*DATA_W-1:0] core_ops,
  input  logic                    core_done,
  input  logic [DATA_W-1:0]       core_result
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(N_OPS);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(N_OPS + 1);
  localparam logic [ADDR_W-1:0] A_RES  = ADDR_W'(N_OPS + 2);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] ops [N_OPS];
  logic [DATA_W-1:0] result;
  logic              irq_en, done;
  logic              busy, ctrl_wr, go, clr;

  assign busy       = (state == START) || (state == WAIT);
  assign ctrl_wr    = we && (addr == A_CTRL);
  assign go         = ctrl_wr && wd[0];
  assign clr        = ctrl_wr && wd[2];
  assign core_start = (state == START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // go beats clr in DONE; both are meaningless while busy
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (core_done) state_nx = DONE;
      DONE: begin
        if (go)       state_nx = START;
        else if (clr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are frozen while busy so core_ops stays stable for the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
    end else begin
      for (int i = 0; i < N_OPS; i++)
        if (we && !busy && (addr == ADDR_W'(i))) ops[i] <= wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      irq    <= 1'b0;
    end else begin
      irq <= done & irq_en;
      if (ctrl_wr) irq_en <= wd[1];
      if ((state == WAIT) && core_done) begin
        result <= core_result;
        done   <= 1'b1;
      end else if (((state == IDLE) || (state == DONE)) && go) begin
        done <= 1'b0;
      end else if ((state == DONE) && clr) begin
        done <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_OPS; i++) core_ops[i*DATA_W +: DATA_W] = ops[i];
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < N_OPS; i++)
      if (addr == ADDR_W'(i)) rd = ops[i];
    if (addr == A_CTRL) rd[1] = irq_en;
    if (addr == A_STAT) begin
      rd[0] = done;
      rd[1] = busy;
      rd[2] = irq_en;
    end
    if (addr == A_RES) rd = result;
  end

endmodule

// File: tb/tb_fpmul_mmio.sv
// Directed plus randomized bench for fpmul_mmio against a register-level model
// of the address map, launch/complete protocol and interrupt timing.
module tb_fpmul_mmio;
  localparam int DW     = 32;
  localparam int N_OPS  = 2;
  localparam int ADDR_W = 3;
  localparam int A_CTRL = N_OPS;
  localparam int A_STAT = N_OPS + 1;
  localparam int A_RES  = N_OPS + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 we = 1'b0;
  logic [ADDR_W-1:0]    addr = '0;
  logic [DW-1:0]        wd = '0;
  logic [DW-1:0]        rd;
  logic                 irq;
  logic                 core_start;
  logic [N_OPS*DW-1:0]  core_ops;
  logic                 core_done = 1'b0;
  logic [DW-1:0]        core_result = '0;

  int passes = 0;
  int checks = 0;
  int start_cnt = 0;

  // Reference model state
  logic [DW-1:0] m_ops [N_OPS];
  logic [DW-1:0] m_result;
  logic          m_irq_en, m_done, m_busy;

  fpmul_mmio #(.DATA_W(DW), .N_OPS(N_OPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd), .irq(irq),
    .core_start(core_start), .core_ops(core_ops), .core_done(core_done),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic checkOutput(input string tag, input logic [N_OPS*DW-1:0] obs,
                             input logic [N_OPS*DW-1:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int a);
    logic [DW-1:0] v;
    v = '0;
    if (a < N_OPS)       v = m_ops[a];
    else if (a == A_CTRL) v[1] = m_irq_en;
    else if (a == A_STAT) v = {29'd0, m_irq_en, m_busy, m_done};
    else if (a == A_RES)  v = m_result;
    return v;
  endfunction

  function automatic logic [N_OPS*DW-1:0] model_ops();
    logic [N_OPS*DW-1:0] v;
    for (int i = 0; i < N_OPS; i++) v[i*DW +: DW] = m_ops[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_OPS; i++) m_ops[i] = '0;
    m_result = '0; m_irq_en = 1'b0; m_done = 1'b0; m_busy = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus write; the model applies it at the same clock edge
  task automatic applyStimulus(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    we = 1'b1; addr = ADDR_W'(a); wd = d;
    @(posedge clk);
    if (a < N_OPS) begin
      if (!m_busy) m_ops[a] = d;
    end else if (a == A_CTRL) begin
      m_irq_en = d[1];
      if (!m_busy) begin
        if (d[0]) begin m_busy = 1'b1; m_done = 1'b0; end
        else if (d[2]) m_done = 1'b0;
      end
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic checkRead(input string tag, input int a);
    addr = ADDR_W'(a);
    #1;
    checkOutput(tag, {{(N_OPS-1)*DW{1'b0}}, rd}, {{(N_OPS-1)*DW{1'b0}}, model_read(a)});
  endtask

  // Core model: pulse core_done with a result after 'extra' further cycles
  task automatic complete_op(input int extra, input logic [DW-1:0] res);
    tick(extra);
    core_done = 1'b1; core_result = res;
    @(posedge clk);
    if (m_busy) begin m_result = res; m_done = 1'b1; m_busy = 1'b0; end
    @(negedge clk);
    core_done = 1'b0;
  endtask

  initial begin
    int s0;
    logic [N_OPS*DW-1:0] ops_snap;
    logic [DW-1:0] r, op0_snap;
    logic ie;
    model_reset();

    // Reset state
    tick(2);
    for (int a = 0; a < 8; a++) checkRead("reset_rd", a);
    checkOutput("reset_irq", irq, 0);
    checkOutput("reset_core_start", core_start, 0);
    @(negedge clk) rst = 1'b0;

    // Basic multiply 2.0 * 3.0
    s0 = start_cnt;
    applyStimulus(0, 32'h40000000);
    applyStimulus(1, 32'h40400000);
    applyStimulus(A_CTRL, 32'h1);
    checkOutput("basic_core_start", core_start, 1);
    checkOutput("basic_core_ops", core_ops, {32'h40400000, 32'h40000000});
    checkRead("basic_status_busy", A_STAT);
    complete_op(4, 32'h40C00000);
    checkRead("basic_status_done", A_STAT);
    checkRead("basic_result", A_RES);
    checkOutput("basic_irq_off", irq, 0);
    tick(1);
    checkOutput("basic_start_count", start_cnt - s0, 1);

    // Interrupt and clear
    applyStimulus(A_CTRL, 32'h4);
    checkRead("clr_status", A_STAT);
    applyStimulus(A_CTRL, 32'h2);
    applyStimulus(A_CTRL, 32'h3);
    complete_op(2, $urandom);
    checkRead("irq_result", A_RES);
    checkOutput("irq_not_yet", irq, 0);
    tick(1);
    checkOutput("irq_rises", irq, 1);
    applyStimulus(A_CTRL, 32'h6);
    checkRead("clr_keep_irq_en", A_STAT);
    tick(1);
    checkOutput("irq_falls", irq, 0);

    // Busy protection
    applyStimulus(0, $urandom);
    applyStimulus(1, $urandom);
    op0_snap = m_ops[0];
    s0 = start_cnt;
    applyStimulus(A_CTRL, 32'h1);
    ops_snap = model_ops();
    applyStimulus(0, 32'hFFFFFFFF);
    applyStimulus(A_CTRL, 32'h1);
    checkOutput("busy_core_ops", core_ops, ops_snap);
    checkRead("busy_status", A_STAT);
    complete_op(1, $urandom);
    tick(1);
    checkOutput("busy_start_count", start_cnt - s0, 1);
    checkOutput("busy_op0_kept", {{(N_OPS-1)*DW{1'b0}}, op0_snap},
                {{(N_OPS-1)*DW{1'b0}}, m_ops[0]});
    checkRead("busy_op0_read", 0);

    // Decode bounds: unmapped addresses ignore writes and read zero
    for (int a = N_OPS + 3; a < 8; a++) applyStimulus(a, $urandom);
    for (int a = 0; a < 8; a++) checkRead("decode", a);

    // Restart precedence (go+clr in DONE) and spurious done in IDLE
    s0 = start_cnt;
    applyStimulus(A_CTRL, 32'h5);
    checkRead("restart_status", A_STAT);
    complete_op(3, $urandom);
    checkRead("restart_result", A_RES);
    applyStimulus(A_CTRL, 32'h4);
    complete_op(1, $urandom);
    checkRead("spurious_result", A_RES);
    checkRead("spurious_status", A_STAT);
    tick(2);
    checkOutput("restart_start_count", start_cnt - s0, 1);

    // Randomized operations
    for (int it = 0; it < 8; it++) begin
      s0 = start_cnt;
      for (int i = 0; i < N_OPS; i++) applyStimulus(i, $urandom);
      ie = 1'($urandom_range(0, 1));
      applyStimulus(A_CTRL, {29'd0, 1'b0, ie, 1'b1});
      checkOutput("rand_core_ops", core_ops, model_ops());
      checkRead("rand_status_busy", A_STAT);
      r = $urandom;
      complete_op($urandom_range(1, 5), r);
      checkRead("rand_result", A_RES);
      tick(1);
      checkOutput("rand_irq", irq, m_done & m_irq_en);
      checkRead("rand_status_done", A_STAT);
      checkOutput("rand_start_count", start_cnt - s0, 1);
    end

    // Asynchronous reset mid-WAIT, then a stray core_done
    applyStimulus(A_CTRL, 32'h3);
    tick(1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checkOutput("areset_irq", irq, 0);
    checkOutput("areset_core_start", core_start, 0);
    for (int a = 0; a < N_OPS + 3; a++) checkRead("areset_rd", a);
    @(negedge clk) rst = 1'b0;
    s0 = start_cnt;
    complete_op(1, $urandom);
    tick(2);
    checkRead("post_reset_result", A_RES);
    checkRead("post_reset_status", A_STAT);
    checkOutput("post_reset_irq", irq, 0);
    checkOutput("post_reset_no_start", start_cnt - s0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end
endmodule
